// File: rtl/synth_pkg.sv
// Shared synthesizer types for the polyphony allocator and its voice slots.
//   wave_shape    : oscillator waveform selector (SAWTOOTH is the reset shape)
//   alloc_state_t : allocator FSM states
//   KEY_W, FREQ_W : note-number and frequency field widths
package synth_pkg;

    typedef enum logic [1:0] {
        SAWTOOTH = 2'd0,
        SQUARE   = 2'd1,
        TRIANGLE = 2'd2,
        SINE     = 2'd3
    } wave_shape;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_t;

    localparam int unsigned KEY_W  = 7;
    localparam int unsigned FREQ_W = 16;

endpackage

// File: rtl/voice_slot.sv
// One oscillator slot: holds enable, key, freq, amplitude, shape and age.
//   load_i     : note-on target, loads all fields, enables, clears age
//   release_i  : note-off, disables and clears age, fields are held
//   age_inc_i  : age step for an enabled slot, saturating
//   *_o        : current slot contents (age_o feeds the allocator scan)
module voice_slot import synth_pkg::*; #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned AGE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              release_i,
    input  logic              age_inc_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [FREQ_W-1:0] freq_i,
    input  logic [WIDTH-1:0]  amp_i,
    input  wave_shape         shape_i,
    output logic              enable_o,
    output logic [KEY_W-1:0]  key_o,
    output logic [FREQ_W-1:0] freq_o,
    output logic [WIDTH-1:0]  amp_o,
    output wave_shape         shape_o,
    output logic [AGE_W-1:0]  age_o
);

    logic              enable_q, enable_d;
    logic [KEY_W-1:0]  key_q,    key_d;
    logic [FREQ_W-1:0] freq_q,   freq_d;
    logic [WIDTH-1:0]  amp_q,    amp_d;
    wave_shape         shape_q,  shape_d;
    logic [AGE_W-1:0]  age_q,    age_d;

    always_comb begin
        enable_d = enable_q;
        key_d    = key_q;
        freq_d   = freq_q;
        amp_d    = amp_q;
        shape_d  = shape_q;
        age_d    = age_q;
        if (load_i) begin
            enable_d = 1'b1;
            key_d    = key_i;
            freq_d   = freq_i;
            amp_d    = amp_i;
            shape_d  = shape_i;
            age_d    = '0;
        end else if (release_i) begin
            enable_d = 1'b0;
            age_d    = '0;
        end else if (age_inc_i && enable_q && (age_q != '1)) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= 1'b0;
            key_q    <= '0;
            freq_q   <= '0;
            amp_q    <= '0;
            shape_q  <= SAWTOOTH;
            age_q    <= '0;
        end else begin
            enable_q <= enable_d;
            key_q    <= key_d;
            freq_q   <= freq_d;
            amp_q    <= amp_d;
            shape_q  <= shape_d;
            age_q    <= age_d;
        end
    end

    assign enable_o = enable_q;
    assign key_o    = key_q;
    assign freq_o   = freq_q;
    assign amp_o    = amp_q;
    assign shape_o  = shape_q;
    assign age_o    = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony allocator: accepts note-on/off events (valid/ready), scans the
// VOICES slots one per cycle for match / free / oldest, then commits.
//   ev_*          : event handshake and fields (latched on acceptance)
//   voice_*       : per-slot oscillator controls
//   busy_count    : number of enabled slots
module voice_allocator import synth_pkg::*; #(
    parameter int unsigned VOICES = 8,
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned AGE_W  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ev_valid,
    output logic                           ev_ready,
    input  logic                           ev_note_on,
    input  logic [KEY_W-1:0]               ev_key,
    input  logic [FREQ_W-1:0]              ev_freq,
    input  logic [WIDTH-1:0]               ev_amplitude,
    input  wave_shape                      ev_shape,
    output logic [VOICES-1:0]              voice_enable,
    output logic [VOICES-1:0][KEY_W-1:0]   voice_key,
    output logic [VOICES-1:0][FREQ_W-1:0]  voice_freq,
    output logic [VOICES-1:0][WIDTH-1:0]   voice_amplitude,
    output wave_shape [VOICES-1:0]         voice_shape,
    output logic [$clog2(VOICES):0]        busy_count
);

    localparam int unsigned IDX_W = $clog2(VOICES);
    localparam int unsigned CNT_W = IDX_W + 1;

    alloc_state_t              state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      live_q;

    logic                      on_q, on_d;
    logic [KEY_W-1:0]          key_q, key_d;
    logic [FREQ_W-1:0]         freq_q, freq_d;
    logic [WIDTH-1:0]          amp_q, amp_d;
    wave_shape                 shape_q, shape_d;

    logic                      match_vld_q, match_vld_d;
    logic [IDX_W-1:0]          match_idx_q, match_idx_d;
    logic                      free_vld_q, free_vld_d;
    logic [IDX_W-1:0]          free_idx_q, free_idx_d;
    logic                      old_vld_q, old_vld_d;
    logic [IDX_W-1:0]          old_idx_q, old_idx_d;
    logic [AGE_W-1:0]          old_age_q, old_age_d;

    logic [VOICES-1:0]         load_q, load_d;
    logic [VOICES-1:0]         rel_q, rel_d;
    logic [VOICES-1:0]         inc_q, inc_d;
    logic [IDX_W-1:0]          tgt;

    logic [VOICES-1:0][AGE_W-1:0] voice_age;

    // live_q keeps ev_ready low until the first edge after reset release.
    assign ev_ready = (state_q == IDLE) && live_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        on_d        = on_q;
        key_d       = key_q;
        freq_d      = freq_q;
        amp_d       = amp_q;
        shape_d     = shape_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        old_vld_d   = old_vld_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        load_d      = '0;
        rel_d       = '0;
        inc_d       = '0;
        tgt         = '0;
        case (state_q)
            IDLE: begin
                if (ev_valid && ev_ready) begin
                    on_d        = ev_note_on;
                    key_d       = ev_key;
                    freq_d      = ev_freq;
                    amp_d       = ev_amplitude;
                    shape_d     = ev_shape;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    old_vld_d   = 1'b0;
                    match_idx_d = '0;
                    free_idx_d  = '0;
                    old_idx_d   = '0;
                    old_age_d   = '0;
                    idx_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (voice_enable[idx_q] && (voice_key[idx_q] == key_q) && !match_vld_q) begin
                    match_vld_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!voice_enable[idx_q] && !free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
                // Strict '>' keeps the lowest index on age ties.
                if (voice_enable[idx_q] && (!old_vld_q || (voice_age[idx_q] > old_age_q))) begin
                    old_vld_d = 1'b1;
                    old_idx_d = idx_q;
                    old_age_d = voice_age[idx_q];
                end
                if (idx_q == IDX_W'(VOICES - 1)) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (on_q) begin
                    if (match_vld_q)      tgt = match_idx_q;
                    else if (free_vld_q)  tgt = free_idx_q;
                    else                  tgt = old_idx_q;
                    load_d      = '0;
                    load_d[tgt] = 1'b1;
                    inc_d       = '1;
                    inc_d[tgt]  = 1'b0;
                end else if (match_vld_q) begin
                    rel_d[match_idx_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Commit strobes are registered so every slot field changes together one
    // edge after COMMIT, while the FSM is already back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            live_q      <= 1'b0;
            on_q        <= 1'b0;
            key_q       <= '0;
            freq_q      <= '0;
            amp_q       <= '0;
            shape_q     <= SAWTOOTH;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            old_vld_q   <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            load_q      <= '0;
            rel_q       <= '0;
            inc_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            live_q      <= 1'b1;
            on_q        <= on_d;
            key_q       <= key_d;
            freq_q      <= freq_d;
            amp_q       <= amp_d;
            shape_q     <= shape_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            old_vld_q   <= old_vld_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            load_q      <= load_d;
            rel_q       <= rel_d;
            inc_q       <= inc_d;
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_slot
        voice_slot #(
            .WIDTH (WIDTH),
            .AGE_W (AGE_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load_q[g]),
            .release_i (rel_q[g]),
            .age_inc_i (inc_q[g]),
            .key_i     (key_q),
            .freq_i    (freq_q),
            .amp_i     (amp_q),
            .shape_i   (shape_q),
            .enable_o  (voice_enable[g]),
            .key_o     (voice_key[g]),
            .freq_o    (voice_freq[g]),
            .amp_o     (voice_amplitude[g]),
            .shape_o   (voice_shape[g]),
            .age_o     (voice_age[g])
        );
    end

    always_comb begin
        busy_count = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            busy_count = busy_count + CNT_W'(voice_enable[i]);
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
    import synth_pkg::*;

    localparam int unsigned V   = 4;
    localparam int unsigned W   = 24;
    localparam int          LAT = V + 2;

    logic                     clk;
    logic                     rst;
    logic                     ev_valid;
    logic                     ev_ready;
    logic                     ev_note_on;
    logic [6:0]               ev_key;
    logic [15:0]              ev_freq;
    logic [W-1:0]             ev_amplitude;
    wave_shape                ev_shape;
    logic [V-1:0]             voice_enable;
    logic [V-1:0][6:0]        voice_key;
    logic [V-1:0][15:0]       voice_freq;
    logic [V-1:0][W-1:0]      voice_amplitude;
    wave_shape [V-1:0]        voice_shape;
    logic [$clog2(V):0]       busy_count;
    logic [2*V-1:0]           shape_bits;

    assign shape_bits = voice_shape;

    voice_allocator #(
        .VOICES (V),
        .WIDTH  (W),
        .AGE_W  (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ev_valid        (ev_valid),
        .ev_ready        (ev_ready),
        .ev_note_on      (ev_note_on),
        .ev_key          (ev_key),
        .ev_freq         (ev_freq),
        .ev_amplitude    (ev_amplitude),
        .ev_shape        (ev_shape),
        .voice_enable    (voice_enable),
        .voice_key       (voice_key),
        .voice_freq      (voice_freq),
        .voice_amplitude (voice_amplitude),
        .voice_shape     (voice_shape),
        .busy_count      (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [V-1:0]        en;
        logic [V-1:0][6:0]   key;
        logic [V-1:0][15:0]  freq;
        logic [V-1:0][W-1:0] amp;
        logic [2*V-1:0]      shape;
    } snap_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    bit    mon_en = 1'b0;
    snap_t expq[$];
    int    hsq[$];
    int    hs_log[$];
    snap_t model;
    snap_t last;
    snap_t e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic check_snap(input string tag, input snap_t s);
        chk({tag, "_enable"}, voice_enable, s.en);
        chk({tag, "_busy"},   busy_count, $countones(s.en));
        chk({tag, "_key"},    voice_key, s.key);
        chk({tag, "_freq"},   voice_freq, s.freq);
        chk({tag, "_amp"},    voice_amplitude, s.amp);
        chk({tag, "_shape"},  shape_bits, s.shape);
    endtask

    // Monitor: logs handshakes, then checks outputs are unchanged one edge
    // before the expected update and match the scoreboard at the update edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (mon_en && ev_valid && ev_ready) begin
                hsq.push_back(cyc);
                hs_log.push_back(cyc);
            end
            #1;
            if (hsq.size() > 0) begin
                if (cyc == hsq[0] + LAT - 1) begin
                    check_snap("early", last);
                end else if (cyc == hsq[0] + LAT) begin
                    void'(hsq.pop_front());
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_update: got handshake at cycle %0d required no event", cyc - LAT);
                    end else begin
                        e = expq.pop_front();
                        check_snap("update", e);
                        last = e;
                    end
                end
            end
        end
    end

    // Issue one event; tgt is the hand-picked slot it should land in (-1: none).
    task automatic send(input bit on, input int key, input int freq, input int amp,
                        input wave_shape sh, input int tgt);
        int n;
        @(negedge clk);
        ev_valid     = 1'b1;
        ev_note_on   = on;
        ev_key       = 7'(key);
        ev_freq      = 16'(freq);
        ev_amplitude = W'(amp);
        ev_shape     = sh;
        if (on) begin
            model.en[tgt]         = 1'b1;
            model.key[tgt]        = 7'(key);
            model.freq[tgt]       = 16'(freq);
            model.amp[tgt]        = W'(amp);
            model.shape[2*tgt+:2] = sh;
        end else if (tgt >= 0) begin
            model.en[tgt] = 1'b0;
        end
        expq.push_back(model);
        n = 0;
        while (!ev_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ev_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: got ev_ready=0 required 1 within 100 cycles");
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        ev_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst          = 1'b1;
        ev_valid     = 1'b0;
        ev_note_on   = 1'b0;
        ev_key       = '0;
        ev_freq      = '0;
        ev_amplitude = '0;
        ev_shape     = SAWTOOTH;
        model        = '{default: '0};
        last         = '{default: '0};

        // Reset values, and ev_ready held low until one edge after release.
        @(negedge clk);
        chk("rst_ready",  ev_ready, 1'b0);
        chk("rst_enable", voice_enable, '0);
        chk("rst_busy",   busy_count, '0);
        chk("rst_shape",  shape_bits, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready_low", ev_ready, 1'b0);
        @(negedge clk);
        chk("rel_ready_high", ev_ready, 1'b1);

        // One committed event, then a reset in the middle of the next scan.
        ev_valid = 1'b1; ev_note_on = 1'b1; ev_key = 7'd10; ev_freq = 16'd100;
        ev_amplitude = W'(1); ev_shape = SINE;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        repeat (LAT) @(negedge clk);
        chk("pre_enable", voice_enable, 4'b0001);
        chk("pre_key0",   voice_key[0], 7'd10);
        ev_valid = 1'b1; ev_key = 7'd11;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midscan_enable", voice_enable, '0);
        chk("midscan_busy",   busy_count, '0);
        chk("midscan_ready",  ev_ready, 1'b0);
        chk("midscan_key",    voice_key, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_ready", ev_ready, 1'b1);
        repeat (LAT + 2) @(negedge clk);
        chk("discard_enable", voice_enable, '0);

        // Scoreboarded event sequence (V = 4).
        mon_en = 1'b1;
        send(1'b1, 60, 262, 24'h100000, SQUARE,   0);  idle(2);
        send(1'b1, 62, 294, 24'h100000, TRIANGLE, 1);  idle(2);
        send(1'b1, 64, 330, 24'h080000, SINE,     2);  idle(2);
        send(1'b1, 62, 294, 24'h200000, TRIANGLE, 1);  idle(2);  // retrigger
        send(1'b0, 64,   0, 0,          SAWTOOTH, 2);  idle(2);  // note-off, key kept
        send(1'b0, 99,   0, 0,          SAWTOOTH, -1); idle(2);  // unmatched
        send(1'b1, 71, 494, 24'h100000, SINE,     2);  idle(2);  // reuses slot 2
        send(1'b1, 65, 349, 24'h100000, SAWTOOTH, 3);  idle(2);
        send(1'b1, 67, 392, 24'h0C0000, SQUARE,   0);  idle(2);  // steal oldest
        send(1'b1, 69, 440, 24'h100000, TRIANGLE, 1);  idle(2);  // steal oldest

        // Backpressure: three events with ev_valid held high throughout.
        base = hs_log.size();
        send(1'b0, 67,   0, 0,          SAWTOOTH, 0);
        send(1'b1, 72, 523, 24'h000000, SQUARE,   0);            // zero amplitude
        send(1'b1, 69, 440, 24'h180000, SINE,     1);            // retrigger
        idle(2);
        chk("bp_count", hs_log.size() - base, 3);
        for (int k = base; k + 1 < hs_log.size(); k++) begin
            chk("bp_spacing", hs_log[k+1] - hs_log[k], LAT);
        end

        send(1'b1, 74, 587, 24'h100000, SINE,     2);            // steal oldest
        idle(LAT + 4);
        chk("sb_drain_exp", expq.size(), 0);
        chk("sb_drain_hs",  hsq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
